// File: rtl/grn_node_lut.sv
// Gene-regulatory-network node: programmable NIN-input LUT evaluated per channel with
// per-channel update divider and stability counter. Optional GRN_NODE_CHG_CNT_EN adds chg_cnt.
module grn_node_lut #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned NIN     = 2,
  parameter int unsigned DIV_W   = 2,
  parameter int unsigned STB_W   = 4,
  parameter int unsigned STB_THR = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_nos,
  input  logic [NCH-1:0]         init_state,
  input  logic [NCH*DIV_W-1:0]   div,
  input  logic                   cfg_we,
  input  logic [(1<<NIN)-1:0]    cfg_lut,
  input  logic [NCH-1:0]         start,
  input  logic [NCH*NIN-1:0]     regs_in,
  output logic [NCH-1:0]         s,
  output logic [NCH-1:0]         changed,
  output logic [NCH-1:0]         stable
`ifdef GRN_NODE_CHG_CNT_EN
  ,
  output logic [NCH*16-1:0]      chg_cnt
`endif
);

  localparam int unsigned LUT_W = 1 << NIN;
  localparam logic [STB_W-1:0] STB_MAX = '1;
  localparam logic [STB_W-1:0] STB_THR_V = STB_W'(STB_THR);

  logic [LUT_W-1:0]              lut_q, lut_d;
  logic [NCH-1:0]                s_q, s_d;
  logic [NCH-1:0]                chg_q, chg_d;
  logic [NCH-1:0][DIV_W-1:0]     skip_q, skip_d;
  logic [NCH-1:0][STB_W-1:0]     stb_q, stb_d;
  logic [NCH-1:0]                nxt;

  // LUT lookup against the currently held table (a same-cycle write is not yet visible)
  always_comb begin
    nxt = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      nxt[c] = lut_q[regs_in[c*NIN +: NIN]];
    end
  end

  always_comb begin
    lut_d  = cfg_we ? cfg_lut : lut_q;
    s_d    = s_q;
    skip_d = skip_q;
    stb_d  = stb_q;
    chg_d  = '0;
    if (reset_nos) begin
      s_d    = init_state;
      skip_d = '0;
      stb_d  = '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (start[c]) begin
          if (skip_q[c] == '0) begin
            s_d[c]    = nxt[c];
            skip_d[c] = div[c*DIV_W +: DIV_W];
            if (nxt[c] != s_q[c]) begin
              chg_d[c] = 1'b1;
              stb_d[c] = '0;
            end else if (stb_q[c] != STB_MAX) begin
              stb_d[c] = stb_q[c] + STB_W'(1);
            end
          end else begin
            skip_d[c] = skip_q[c] - DIV_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_q  <= '0;
      s_q    <= '0;
      chg_q  <= '0;
      skip_q <= '0;
      stb_q  <= '0;
    end else begin
      lut_q  <= lut_d;
      s_q    <= s_d;
      chg_q  <= chg_d;
      skip_q <= skip_d;
      stb_q  <= stb_d;
    end
  end

  always_comb begin
    stable = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      stable[c] = (stb_q[c] >= STB_THR_V);
    end
  end

  assign s       = s_q;
  assign changed = chg_q;

`ifdef GRN_NODE_CHG_CNT_EN
  logic [NCH-1:0][15:0] cnt_q, cnt_d;

  // Counts on the same edge that raises changed
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (reset_nos) begin
        cnt_d[c] = '0;
      end else if (chg_d[c] && (cnt_q[c] != 16'hFFFF)) begin
        cnt_d[c] = cnt_q[c] + 16'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign chg_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_grn_node_lut.sv
// Directed table-driven bench for grn_node_lut (default parameters, NCH=2, NIN=2).
module tb_grn_node_lut;

  logic       clk;
  logic       rst;
  logic       reset_nos;
  logic [1:0] init_state;
  logic [3:0] div;
  logic       cfg_we;
  logic [3:0] cfg_lut;
  logic [1:0] start;
  logic [3:0] regs_in;
  logic [1:0] s;
  logic [1:0] changed;
  logic [1:0] stable;
`ifdef GRN_NODE_CHG_CNT_EN
  logic [31:0] chg_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  grn_node_lut dut (
    .clk        (clk),
    .rst        (rst),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .div        (div),
    .cfg_we     (cfg_we),
    .cfg_lut    (cfg_lut),
    .start      (start),
    .regs_in    (regs_in),
    .s          (s),
    .changed    (changed),
    .stable     (stable)
`ifdef GRN_NODE_CHG_CNT_EN
    ,
    .chg_cnt    (chg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       nos;
    logic [1:0] init;
    logic [3:0] div;
    logic       we;
    logic [3:0] lut;
    logic [1:0] start;
    logic [3:0] regs;
    logic [1:0] es;
    logic [1:0] ec;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic n, input logic [1:0] i,
                              input logic [3:0] d, input logic w, input logic [3:0] l,
                              input logic [1:0] st, input logic [3:0] rg,
                              input logic [1:0] es, input logic [1:0] ec,
                              input logic [1:0] est);
    vec_t v;
    v.rst = r; v.nos = n; v.init = i; v.div = d; v.we = w; v.lut = l;
    v.start = st; v.regs = rg; v.es = es; v.ec = ec; v.est = est;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; reset_nos = v.nos; init_state = v.init; div = v.div;
    cfg_we = v.we; cfg_lut = v.lut; start = v.start; regs_in = v.regs;
  endtask

  task automatic check(input string name, input logic [1:0] es, input logic [1:0] ec,
                       input logic [1:0] est);
    n_vec++;
    if (s !== es || changed !== ec || stable !== est) begin
      n_err++;
      $display("FAIL %s: s=%b changed=%b stable=%b, required s=%b changed=%b stable=%b",
               name, s, changed, stable, es, ec, est);
    end
  endtask

  initial begin
    drive(mk(1, 0, 2'b00, 4'h0, 0, 4'h0, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00));

    //         rst nos init   div    we lut      start  regs     s      chg    stb
    vecs.push_back(mk(1, 0, 2'b00, 4'h0, 0, 4'h0,    2'b00, 4'h0,  2'b00, 2'b00, 2'b00)); // 0 reset
    vecs.push_back(mk(0, 0, 2'b00, 4'h0, 1, 4'b0111, 2'b00, 4'h0,  2'b00, 2'b00, 2'b00)); // 1 NAND load
    vecs.push_back(mk(0, 1, 2'b01, 4'h0, 0, 4'h0,    2'b00, 4'h0,  2'b01, 2'b00, 2'b00)); // 2 reset_nos
    vecs.push_back(mk(0, 1, 2'b11, 4'h0, 0, 4'h0,    2'b00, 4'h0,  2'b11, 2'b00, 2'b00)); // 3
    vecs.push_back(mk(0, 0, 2'b00, 4'b0100, 0, 4'h0, 2'b11, 4'b1111, 2'b00, 2'b11, 2'b00)); // 4 both update
    vecs.push_back(mk(0, 0, 2'b00, 4'b0100, 0, 4'h0, 2'b11, 4'b0011, 2'b00, 2'b00, 2'b00)); // 5 ch1 skips
    vecs.push_back(mk(0, 0, 2'b00, 4'b0100, 0, 4'h0, 2'b11, 4'b0011, 2'b10, 2'b10, 2'b00)); // 6 ch1 updates
    vecs.push_back(mk(0, 0, 2'b00, 4'b1100, 0, 4'h0, 2'b11, 4'b1111, 2'b10, 2'b00, 2'b00)); // 7 skip, div->3
    vecs.push_back(mk(0, 0, 2'b00, 4'b1100, 0, 4'h0, 2'b11, 4'b1111, 2'b00, 2'b10, 2'b00)); // 8 reload 3
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b0011, 2'b00, 2'b00, 2'b00)); // 9 div change mid-skip
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b0011, 2'b00, 2'b00, 2'b00)); // 10
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b0011, 2'b00, 2'b00, 2'b00)); // 11 ch0 count 7
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b0011, 2'b10, 2'b10, 2'b01)); // 12 ch0 count 8
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b01, 4'b0000, 2'b11, 2'b01, 2'b00)); // 13 flip drops stable
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b00, 4'b0000, 2'b11, 2'b00, 2'b00)); // 14 idle
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 0, 4'h0, 2'b11, 4'b0000, 2'b10, 2'b00, 2'b00)); // 15 nos beats start
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b01, 4'b0000, 2'b11, 2'b01, 2'b00)); // 16 skip was cleared
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 1, 4'b1000, 2'b11, 4'b1111, 2'b00, 2'b11, 2'b00)); // 17 old LUT used
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b1111, 2'b11, 2'b11, 2'b00)); // 18 new LUT
    vecs.push_back(mk(1, 1, 2'b11, 4'b0000, 0, 4'h0, 2'b11, 4'b1111, 2'b00, 2'b00, 2'b00)); // 19 rst beats nos
    vecs.push_back(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b1111, 2'b00, 2'b00, 2'b00)); // 20 LUT cleared

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].est);
    end

    // Stable counters keep counting past the threshold and must saturate, not wrap
    drive(mk(0, 0, 2'b00, 4'b0000, 0, 4'h0, 2'b11, 4'b1111, 2'b00, 2'b00, 2'b00));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat%0d", k), 2'b00, 2'b00, ((k + 2) >= 8) ? 2'b11 : 2'b00);
    end

`ifdef GRN_NODE_CHG_CNT_EN
    drive(mk(0, 1, 2'b00, 4'h0, 1, 4'b0111, 2'b00, 4'h0, 2'b00, 2'b00, 2'b00));
    @(posedge clk);
    #1;
    n_vec++;
    if (chg_cnt[15:0] !== 16'd0) begin
      n_err++;
      $display("FAIL cnt_clr0: chg_cnt0=%0d, required 0", chg_cnt[15:0]);
    end
    for (int k = 0; k < 3; k++) begin
      drive(mk(0, 0, 2'b00, 4'h0, 0, 4'h0, 2'b01, (k % 2 == 0) ? 4'b0000 : 4'b0011,
               2'b00, 2'b00, 2'b00));
      @(posedge clk);
      #1;
    end
    start = 2'b00;
    n_vec++;
    if (chg_cnt[15:0] !== 16'd3 || chg_cnt[31:16] !== 16'd0) begin
      n_err++;
      $display("FAIL cnt3: chg_cnt0=%0d chg_cnt1=%0d, required 3 and 0",
               chg_cnt[15:0], chg_cnt[31:16]);
    end
    reset_nos = 1'b1;
    @(posedge clk);
    #1;
    reset_nos = 1'b0;
    n_vec++;
    if (chg_cnt[15:0] !== 16'd0) begin
      n_err++;
      $display("FAIL cnt_nos: chg_cnt0=%0d, required 0", chg_cnt[15:0]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/grn_node_lut.md
Name: grn_node_lut

Overview:
Parametrised gene-regulatory-network node that evaluates a programmable Boolean function over NIN regulator inputs for NCH independent simulation channels. Each channel has its own update divider, so one node can model synchronous and delayed update schemes. It also has a stability detector for attractor search. It sits in the GRN core alongside other nodes and is driven by the network sequencer (start/reset_nos) and by neighbouring node outputs.

Parameters:
NCH, 2, number of independent state channels
NIN, 2, regulator inputs per channel (LUT has 2^NIN entries)
DIV_W, 2, width of per-channel update-divider value
STB_W, 4, width of per-channel stable-update counter
STB_THR, 8, stable-count threshold that asserts stable (must be < 2^STB_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
reset_nos  in  1  reload all channels with init_state
init_state  in  NCH  per-channel initial state
div  in  NCH*DIV_W  per-channel divider value; channel c uses bits [c*DIV_W +: DIV_W]
cfg_we  in  1  write LUT
cfg_lut  in  2^NIN  truth table; bit i is the output for input pattern i
start  in  NCH  per-channel update request
regs_in  in  NCH*NIN  regulator values; channel c uses bits [c*NIN +: NIN]
s  out  NCH  node state per channel (registered)
changed  out  NCH  one-cycle pulse when an update flips the state
stable  out  NCH  stable count >= STB_THR

Behaviour:
- Reset rst is synchronous and active-high; clock is clk. Priority: rst > reset_nos > start. cfg_we is independent of all three.
- rst effect:
  - s, changed, skip counters and stable counters all go to 0.
  - LUT goes to 0.
  - stable is therefore 0.
- LUT write: when cfg_we=1, LUT <= cfg_lut at the clock edge. An update sampled in the same cycle uses the old LUT.
- reset_nos (rst=0), all channels:
  - s[c] <= init_state[c]; skip[c] <= 0; stable counter <= 0; changed <= 0.
  - start is ignored in that cycle.
- start[c]=1 (no rst, no reset_nos):
  - If skip[c]==0, the channel performs an update:
    - nxt = LUT[regs_in_c]; s[c] <= nxt; skip[c] <= div_c.
    - If nxt != s[c]: changed[c] <= 1 and stable counter <= 0.
    - Otherwise: changed[c] <= 0 and stable counter increments, saturating at 2^STB_W-1.
  - If skip[c]!=0: skip[c] <= skip[c]-1; s unchanged; changed[c] <= 0.
- start[c]=0: state, skip and stable counter hold; changed[c] <= 0.
- Latency: s and changed are valid one cycle after the sampling edge.
- Cadence: div_c=0 updates on every start; div_c=D updates on the 1st, (D+2)th, (2D+3)th start, and so on.
- div is sampled only when an update reloads skip. Changing div mid-skip does not alter the current count.
- stable[c] is combinational from the registered counter (counter >= STB_THR). It stays asserted while saturated.
- Channels are fully independent; simultaneous starts on different channels do not interact.
- rst asserted mid-skip or mid-count clears everything, including the LUT. The LUT must be reprogrammed afterwards.

Optional Feature:
GRN_NODE_CHG_CNT_EN
- Defined: adds output chg_cnt (NCH*16), a per-channel saturating count of changed pulses.
  - Cleared by rst and reset_nos.
  - Increments the cycle after each changed pulse is generated (same edge that sets changed).
  - Saturates at 16'hFFFF.
- Undefined: no port and no counters; the rest of the behaviour is identical.

Test Plan:
- Reset and LUT load: rst 1 cycle -> s=0, changed=0, stable=0. Then cfg_we with cfg_lut=4'b0111 (NAND), reset_nos with init_state=2'b01 -> s=2'b01 the next cycle.
- Divider cadence: div={2'd1,2'd0}, regs_in=all 1 (NAND->0), init_state=2'b11, start=2'b11 every cycle for 4 cycles:
  - ch0 updates on the 1st start: s0=0, changed0 pulses once.
  - ch1 updates on the 1st start (s1=0); its 2nd start is skipped; its 3rd start updates with no change.
- Stability: STB_THR=8, regs_in constant so nxt==s, div=0, 8 starts -> stable asserts after the 8th update edge. A subsequent regs_in flip with start -> changed pulses and stable drops the next cycle.
- Priority: reset_nos and start together with skip=0 -> s=init_state, skip=0, no changed. rst together with reset_nos -> all zero.
- LUT write collision: cfg_we(new LUT=4'b1000) and start in the same cycle -> s uses the old LUT. The next start uses 4'b1000.
- Optional (GRN_NODE_CHG_CNT_EN): 3 state flips on ch0 -> chg_cnt[15:0]=3. Then reset_nos -> 0.
